// File: rtl/rtlola_verdict_emitter.sv
// rtlola_verdict_emitter: snapshots active monitor outputs into a FIFO and
// streams them as one tagged valid/ready beat per active stream.
module rtlola_verdict_emitter #(
  parameter int NUM_OUTPUTS = 6,
  parameter int DATA_W = 64,
  parameter int TS_W = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] outs,
  input  logic [NUM_OUTPUTS-1:0]        outs_aktv,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic [2:0]                    m_id,
  output logic [TS_W-1:0]               m_ts,
  output logic                          m_last,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = NUM_OUTPUTS + NUM_OUTPUTS*DATA_W + TS_W;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [TS_W-1:0] ts, cur_ts, nts;
  logic [NUM_OUTPUTS-1:0] cur_mask, nmask;
  logic [NUM_OUTPUTS*DATA_W-1:0] cur_vals, nvals;
  logic push, pop, acc, drop, hs, nlast;
  logic [2:0] nid;
  logic [DATA_W-1:0] ndata;
  assign hs = m_valid && m_ready;
  assign push = en && |outs_aktv;
  assign acc = push && (cnt != FULL || pop);
  assign drop = push && !acc;
  // Next snapshot state: consume the lowest mask bit on handshake, reload on pop
  always_comb begin
    state_n = state;
    pop = 1'b0;
    nmask = hs ? cur_mask & (cur_mask - NUM_OUTPUTS'(1)) : cur_mask;
    nvals = cur_vals;
    nts = cur_ts;
    if ((state == IDLE || (hs && m_last)) && cnt != '0) begin
      pop = 1'b1;
      {nmask, nvals, nts} = mem[rp];
      state_n = SEND;
    end else if (state == SEND && hs && m_last) begin
      state_n = IDLE;
    end
  end
  // Beat presented next cycle: lowest remaining stream
  always_comb begin
    nid = '0;
    ndata = '0;
    for (int i = NUM_OUTPUTS-1; i >= 0; i--)
      if (nmask[i]) begin
        nid = 3'(i);
        ndata = nvals[i*DATA_W +: DATA_W];
      end
    nlast = |nmask && ((nmask & (nmask - NUM_OUTPUTS'(1))) == '0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ts <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
      cur_mask <= '0;
      cur_vals <= '0;
      cur_ts <= '0;
      m_valid <= 1'b0;
      m_id <= '0;
      m_data <= '0;
      m_ts <= '0;
      m_last <= 1'b0;
    end else begin
      state <= state_n;
      ts <= ts + TS_W'(en);
      cnt <= cnt + (AW+1)'(acc) - (AW+1)'(pop);
      if (acc) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      overflow <= overflow | drop;
      if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;
      cur_mask <= nmask;
      cur_vals <= nvals;
      cur_ts <= nts;
      m_valid <= state_n == SEND;
      m_id <= nid;
      m_data <= ndata;
      m_ts <= nts;
      m_last <= nlast;
    end
  always_ff @(posedge clk)
    if (acc) mem[wp] <= {outs_aktv, outs, ts};
endmodule

// File: tb/tb_rtlola_verdict_emitter.sv
// tb_rtlola_verdict_emitter: directed stimulus with a beat scoreboard checked by a monitor.
module tb_rtlola_verdict_emitter;
  localparam int N = 6, DW = 64, TW = 32;
  logic clk = 0, rst = 1, en = 0, m_ready = 0;
  logic [N*DW-1:0] outs = '0;
  logic [N-1:0] outs_aktv = '0;
  logic m_valid, m_last, overflow;
  logic [DW-1:0] m_data;
  logic [2:0] m_id;
  logic [TW-1:0] m_ts;
  logic [15:0] drop_count;
  typedef struct packed {logic [DW-1:0] d; logic [2:0] id; logic [TW-1:0] ts; logic last;} beat_t;
  beat_t sb[$];
  beat_t e;
  int checks = 0, errors = 0, nbeats = 0;
  logic [TW-1:0] exp_ts = '0;

  always #5 clk = ~clk;

  rtlola_verdict_emitter dut (
    .clk(clk), .rst(rst), .en(en), .outs(outs), .outs_aktv(outs_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .m_ts(m_ts), .m_last(m_last), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && m_valid && m_ready) begin
      nbeats++;
      if (sb.size() == 0) chk("unexpected_beat", 128'(m_valid), 128'(0));
      else begin
        e = sb.pop_front();
        chk("beat_data", 128'(m_data), 128'(e.d));
        chk("beat_id", 128'(m_id), 128'(e.id));
        chk("beat_ts", 128'(m_ts), 128'(e.ts));
        chk("beat_last", 128'(m_last), 128'(e.last));
      end
    end

  task automatic step();
    @(posedge clk);
    if (rst) exp_ts = '0;
    else if (en) exp_ts++;
    #1;
  endtask

  task automatic expect_snap(input logic [N-1:0] mk, input logic [N*DW-1:0] v, input logic [TW-1:0] t);
    for (int i = 0; i < N; i++)
      if (mk[i]) sb.push_back('{d: v[i*DW +: DW], id: 3'(i), ts: t, last: ((mk >> (i+1)) == 0)});
  endtask

  task automatic cap(input logic [N-1:0] mk, input logic [N*DW-1:0] v, input bit keep);
    outs = v;
    outs_aktv = mk;
    if (keep) expect_snap(mk, v, exp_ts);
    step();
    outs_aktv = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 128'(sb.size()), 128'(0));
    step();
  endtask

  function automatic logic [N*DW-1:0] vec(input int base);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*DW-1:0] v;
    logic [TW-1:0] t0;
    repeat (3) step();
    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_last", 128'(m_last), 128'(0));
    chk("rst_data", 128'(m_data), 128'(0));
    chk("rst_ts", 128'(m_ts), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_drops", 128'(drop_count), 128'(0));
    rst = 0; en = 1; m_ready = 1;
    // streams 0 and 3, values 1 and -5, ts 0
    v = '0; v[0 +: DW] = 64'd1; v[3*DW +: DW] = -64'sd5;
    outs = v; outs_aktv = 6'b001001;
    sb.push_back('{d: 64'd1, id: 3'd0, ts: 32'd0, last: 1'b0});
    sb.push_back('{d: -64'sd5, id: 3'd3, ts: 32'd0, last: 1'b1});
    step(); outs_aktv = '0;
    chk("t1_valid_at_capture", 128'(m_valid), 128'(0));
    step();
    chk("t1_valid_next", 128'(m_valid), 128'(1));
    chk("t1_first_id", 128'(m_id), 128'(0));
    drain("t1");
    // backpressure
    m_ready = 0;
    t0 = exp_ts;
    cap(6'b100110, vec(10), 1);
    step();
    chk("bp_valid", 128'(m_valid), 128'(1));
    repeat (10) begin
      step();
      chk("bp_hold", 128'({m_valid, m_data, m_id, m_ts, m_last}), 128'({1'b1, 64'd11, 3'd1, t0, 1'b0}));
    end
    m_ready = 1;
    step();
    chk("bp_nogap1", 128'(m_valid), 128'(1));
    chk("bp_id2", 128'(m_id), 128'(2));
    step();
    chk("bp_nogap2", 128'(m_valid), 128'(1));
    chk("bp_last", 128'(m_last), 128'(1));
    drain("bp");
    // overflow: one snapshot parked in the emitter, then 10 full captures
    m_ready = 0;
    cap(6'b000001, vec(200), 1);
    step();
    for (int k = 0; k < 10; k++) begin
      cap(6'b111111, vec(16*k), k < 8);
      chk("ov_drops_k", 128'(drop_count), 128'(k < 8 ? 0 : k - 7));
    end
    chk("ov_flag", 128'(overflow), 128'(1));
    nbeats = 0; m_ready = 1;
    drain("ov");
    chk("ov_beats", 128'(nbeats), 128'(49));
    // full FIFO and last-beat pop at the same edge as a capture
    m_ready = 0;
    cap(6'b010000, vec(300), 1);
    step();
    for (int k = 0; k < 8; k++) cap(6'b000011, vec(400 + 2*k), 1);
    chk("fp_drops_full", 128'(drop_count), 128'(2));
    m_ready = 1;
    cap(6'b000011, vec(500), 1);
    chk("fp_drops", 128'(drop_count), 128'(2));
    chk("fp_overflow_sticky", 128'(overflow), 128'(1));
    drain("fp");
    // en=0 freezes ts and capture; in-flight snapshot still drains
    t0 = exp_ts;
    cap(6'b010101, vec(600), 1);
    en = 0; outs_aktv = '1;
    repeat (5) step();
    chk("en_inflight_done", 128'(sb.size()), 128'(0));
    chk("en_no_capture", 128'(m_valid), 128'(0));
    outs_aktv = '0; en = 1;
    outs = vec(700); outs_aktv = 6'b000001;
    sb.push_back('{d: 64'd700, id: 3'd0, ts: t0 + 32'd1, last: 1'b1});
    step(); outs_aktv = '0;
    drain("en");
    // reset mid-snapshot after the first of three beats
    m_ready = 0;
    cap(6'b000111, vec(800), 1);
    step();
    m_ready = 1; step(); m_ready = 0;
    chk("mid_id", 128'(m_id), 128'(1));
    #1 rst = 1; #1;
    chk("mid_rst_valid", 128'(m_valid), 128'(0));
    chk("mid_rst_id", 128'(m_id), 128'(0));
    chk("mid_rst_drops", 128'(drop_count), 128'(0));
    chk("mid_rst_overflow", 128'(overflow), 128'(0));
    sb.delete();
    step(); step();
    rst = 0;
    step();
    chk("post_rst_empty", 128'(m_valid), 128'(0));
    step(); step();
    outs = vec(900); outs_aktv = 6'b001000;
    sb.push_back('{d: 64'd903, id: 3'd3, ts: 32'd3, last: 1'b1});
    step(); outs_aktv = '0;
    m_ready = 1;
    drain("post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
